// File: rtl/x_uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// Bytes come in over a valid/accept handshake with no buffering.
module x_uart_tx #(
   parameter int p_clks_per_bit = 104
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_accept,
   output logic       o_tx,
   output logic       o_busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam logic [15:0] LAST_CNT = 16'(p_clks_per_bit - 1);

   state_t      state_r, state_s;
   logic [15:0] cnt_r, cnt_s;
   logic [2:0]  idx_r, idx_s;
   logic [7:0]  shreg_r, shreg_s;
   logic        tx_r, tx_s;
   logic        bit_end_s;
   logic        accept_s;

   // Held in reset, accept is gated off so no byte is consumed while the block is cleared.
   assign accept_s = (state_r == IDLE) & i_valid & i_rst_n;
   assign bit_end_s = (cnt_r == LAST_CNT);

   // Next-state, counters, shift register and next line level.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      shreg_s = shreg_r;
      tx_s    = tx_r;

      if (state_r == IDLE) begin
         cnt_s = 16'd0;
      end else if (bit_end_s) begin
         cnt_s = 16'd0;
      end else begin
         cnt_s = cnt_r + 16'd1;
      end

      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = START;
               shreg_s = i_data;
               tx_s    = 1'b0;
            end else begin
               tx_s    = 1'b1;
            end
         end
         START: begin
            if (bit_end_s) begin
               state_s = DATA;
               idx_s   = 3'd0;
               tx_s    = shreg_r[0];
            end else begin
               tx_s    = 1'b0;
            end
         end
         DATA: begin
            if (bit_end_s) begin
               shreg_s = {1'b0, shreg_r[7:1]};
               if (idx_r == 3'd7) begin
                  state_s = STOP;
                  tx_s    = 1'b1;
               end else begin
                  idx_s   = idx_r + 3'd1;
                  tx_s    = shreg_r[1];
               end
            end else begin
               tx_s = shreg_r[0];
            end
         end
         STOP: begin
            tx_s = 1'b1;
            if (bit_end_s) begin
               state_s = IDLE;
            end else begin
               state_s = STOP;
            end
         end
         default: begin
            state_s = IDLE;
            tx_s    = 1'b1;
         end
      endcase
   end

   // State and datapath registers; the line level is registered so o_tx is glitch-free.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= IDLE;
         cnt_r   <= 16'd0;
         idx_r   <= 3'd0;
         shreg_r <= 8'd0;
         tx_r    <= 1'b1;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
         shreg_r <= shreg_s;
         tx_r    <= tx_s;
      end
   end

   assign o_accept = accept_s;
   assign o_tx     = tx_r;
   assign o_busy   = (state_r != IDLE);

endmodule
